soc_region_decoder: RTL and testbench

SOC_REGION_DECODER -- requirements
Module: soc_region_decoder

---
 rtl/soc_region_decoder.sv | 141 ++++++++++++++
 tb/tb_soc_region_decoder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_region_decoder.sv
// Programmable address-region decoder: lowest-index region match, one-cycle registered response,
// lockable region table. SOC_REGION_DECODER_STATS_EN adds a saturating decode-miss counter.
module soc_region_decoder #(
  parameter int unsigned NumRegions = 12,
  parameter int unsigned AddrWidth  = 64,
  parameter logic [NumRegions-1:0][AddrWidth-1:0] RstBase = '0,
  parameter logic [NumRegions-1:0][AddrWidth-1:0] RstLen  = '0,
  parameter logic [NumRegions-1:0][2:0]           RstAttr = '0,
  localparam int unsigned IdxW = (NumRegions > 1) ? $clog2(NumRegions) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_we_i,
  input  logic [IdxW-1:0]      cfg_idx_i,
  input  logic [AddrWidth-1:0] cfg_base_i,
  input  logic [AddrWidth-1:0] cfg_len_i,
  input  logic [2:0]           cfg_attr_i,
  input  logic                 cfg_lock_i,
  output logic                 cfg_err_o,
  output logic                 locked_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_hit_o,
  output logic [IdxW-1:0]      rsp_idx_o,
  output logic [2:0]           rsp_attr_o,
  output logic [15:0]          miss_cnt_o
);

  logic [AddrWidth-1:0] base_q [NumRegions];
  logic [AddrWidth-1:0] len_q  [NumRegions];
  logic [2:0]           attr_q [NumRegions];
  logic                 locked_q, cfg_err_q;

  logic                 rsp_valid_q, rsp_hit_q;
  logic [IdxW-1:0]      rsp_idx_q;
  logic [2:0]           rsp_attr_q;

  logic                  cfg_idx_ok, cfg_wr_ok, cfg_wr_err;
  logic                  req_accept;
  logic [NumRegions-1:0] match;
  logic                  dec_hit;
  logic [IdxW-1:0]       dec_idx;
  logic [2:0]            dec_attr;

  assign cfg_idx_ok = 32'(cfg_idx_i) < NumRegions;
  assign cfg_wr_ok  = cfg_we_i && !locked_q && cfg_idx_ok;
  assign cfg_wr_err = cfg_we_i && (locked_q || !cfg_idx_ok);

  assign req_ready_o = !rsp_valid_q || rsp_ready_i;
  assign req_accept  = req_valid_i && req_ready_o;

  // Offset compare keeps regions ending at the top of the address space from wrapping.
  always_comb begin
    match = '0;
    for (int i = 0; i < NumRegions; i++) begin
      match[i] = (len_q[i] != '0) && (req_addr_i >= base_q[i]) &&
                 ((req_addr_i - base_q[i]) < len_q[i]);
    end
  end

  // Descending scan so the lowest matching index is the one that sticks.
  always_comb begin
    dec_hit  = 1'b0;
    dec_idx  = '0;
    dec_attr = '0;
    for (int i = NumRegions - 1; i >= 0; i--) begin
      if (match[i]) begin
        dec_hit  = 1'b1;
        dec_idx  = IdxW'(i);
        dec_attr = attr_q[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRegions; i++) begin
        base_q[i] <= RstBase[i];
        len_q[i]  <= RstLen[i];
        attr_q[i] <= RstAttr[i];
      end
      locked_q  <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NumRegions; i++) begin
        if (cfg_wr_ok && (cfg_idx_i == IdxW'(i))) begin
          base_q[i] <= cfg_base_i;
          len_q[i]  <= cfg_len_i;
          attr_q[i] <= cfg_attr_i;
        end
      end
      if (cfg_lock_i) begin
        locked_q <= 1'b1;
      end
      cfg_err_q <= cfg_wr_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_attr_q  <= '0;
    end else if (req_accept) begin
      rsp_valid_q <= 1'b1;
      rsp_hit_q   <= dec_hit;
      rsp_idx_q   <= dec_idx;
      rsp_attr_q  <= dec_attr;
    end else if (rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

`ifdef SOC_REGION_DECODER_STATS_EN
  logic [15:0] miss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      miss_cnt_q <= '0;
    end else if (req_accept && !dec_hit && (miss_cnt_q != 16'hFFFF)) begin
      miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign miss_cnt_o = miss_cnt_q;
`else
  assign miss_cnt_o = '0;
`endif

  assign cfg_err_o   = cfg_err_q;
  assign locked_o    = locked_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_hit_o   = rsp_hit_q;
  assign rsp_idx_o   = rsp_idx_q;
  assign rsp_attr_o  = rsp_attr_q;

endmodule

// File: tb/tb_soc_region_decoder.sv
// Randomized bench for soc_region_decoder: a table-level reference model checked every cycle,
// plus directed literal checks for the address-boundary, priority, lock and saturation cases.
module tb_soc_region_decoder;

  localparam int N = 12;
  localparam logic [N-1:0][63:0] TbRstBase = 768'h8000_0000;
  localparam logic [N-1:0][63:0] TbRstLen  = 768'h4000_0000;
  localparam logic [N-1:0][2:0]  TbRstAttr = 36'h7;
`ifdef SOC_REGION_DECODER_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we, cfg_lock, cfg_err, locked;
  logic [3:0]  cfg_idx;
  logic [63:0] cfg_base, cfg_len;
  logic [2:0]  cfg_attr;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_hit;
  logic [63:0] req_addr;
  logic [3:0]  rsp_idx;
  logic [2:0]  rsp_attr;
  logic [15:0] miss_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  soc_region_decoder #(
    .NumRegions(N),
    .AddrWidth (64),
    .RstBase   (TbRstBase),
    .RstLen    (TbRstLen),
    .RstAttr   (TbRstAttr)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cfg_we_i   (cfg_we),
    .cfg_idx_i  (cfg_idx),
    .cfg_base_i (cfg_base),
    .cfg_len_i  (cfg_len),
    .cfg_attr_i (cfg_attr),
    .cfg_lock_i (cfg_lock),
    .cfg_err_o  (cfg_err),
    .locked_o   (locked),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_addr_i (req_addr),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_hit_o  (rsp_hit),
    .rsp_idx_o  (rsp_idx),
    .rsp_attr_o (rsp_attr),
    .miss_cnt_o (miss_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the region table as plain arrays, updated once per rising edge.
  logic [63:0] m_base [N];
  logic [63:0] m_len  [N];
  logic [2:0]  m_attr [N];
  bit          m_init = 1'b0;
  bit          m_locked, m_err, m_valid, m_hit;
  int          m_idx;
  logic [2:0]  m_rattr;
  int          m_cnt;

  function automatic int lookup(input logic [63:0] a);
    for (int i = 0; i < N; i++) begin
      if (m_len[i] != 0 && a >= m_base[i] && (a - m_base[i]) < m_len[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_base[i] = (i == 0) ? 64'h8000_0000 : 64'h0;
        m_len[i]  = (i == 0) ? 64'h4000_0000 : 64'h0;
        m_attr[i] = (i == 0) ? 3'h7 : 3'h0;
      end
      m_locked = 0; m_err = 0; m_valid = 0; m_hit = 0; m_idx = 0; m_rattr = 0; m_cnt = 0;
      m_init = 1'b1;
    end else if (m_init) begin
      int  hit_i;
      bit  err;
      hit_i = lookup(req_addr);
      if (req_valid && (!m_valid || rsp_ready)) begin
        m_valid = 1;
        m_hit   = hit_i >= 0;
        m_idx   = (hit_i >= 0) ? hit_i : 0;
        m_rattr = (hit_i >= 0) ? m_attr[hit_i] : 3'h0;
        if (hit_i < 0 && Stats && m_cnt < 65535) m_cnt++;
      end else if (rsp_ready) begin
        m_valid = 0;
      end
      err = cfg_we && (m_locked || cfg_idx >= N);
      if (cfg_we && !err) begin
        m_base[cfg_idx] = cfg_base;
        m_len[cfg_idx]  = cfg_len;
        m_attr[cfg_idx] = cfg_attr;
      end
      m_err = err;
      if (cfg_lock) m_locked = 1;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("rsp_valid", rsp_valid, m_valid);
      check("req_ready", req_ready, !m_valid || rsp_ready);
      check("cfg_err", cfg_err, m_err);
      check("locked", locked, m_locked);
      check("miss_cnt", miss_cnt, m_cnt);
      if (m_valid) begin
        check("rsp_hit", rsp_hit, m_hit);
        check("rsp_idx", rsp_idx, m_idx);
        check("rsp_attr", rsp_attr, m_rattr);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int idx, input logic [63:0] b, input logic [63:0] l,
                    input logic [2:0] a);
    cfg_we = 1; cfg_idx = 4'(idx); cfg_base = b; cfg_len = l; cfg_attr = a;
    cyc();
    cfg_we = 0;
  endtask

  task automatic rand_phase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       req_addr = 64'h1000_0000 + 64'($urandom_range(0, 'h1800));
        1:       req_addr = 64'hFFFF_FFFF_FFFF_F000 + 64'($urandom_range(0, 'hFFF));
        2:       req_addr = 64'hBFFF_F000 + 64'($urandom_range(0, 'h2000));
        default: req_addr = 64'h2000_0000 + 64'($urandom_range(0, 'h11000));
      endcase
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_idx  = 4'($urandom_range(6, 15));
      cfg_base = 64'h2000_0000 + (64'($urandom_range(0, 15)) << 12);
      cfg_len  = 64'($urandom_range(0, 3)) * 64'h800;
      cfg_attr = 3'($urandom);
      cyc();
    end
    cfg_we = 0; req_valid = 0; rsp_ready = 1;
    cyc();
  endtask

  initial begin
    rst_n = 0; cfg_we = 0; cfg_idx = 0; cfg_base = 0; cfg_len = 0; cfg_attr = 0;
    cfg_lock = 0; req_valid = 0; req_addr = 0; rsp_ready = 0;
    repeat (2) cyc();
    rst_n = 1;
    check("reset_valid", rsp_valid, 0);
    check("reset_ready", req_ready, 1);
    check("reset_locked", locked, 0);
    check("reset_miss", miss_cnt, 0);

    // Top byte of the reset region, then the first address past it.
    rsp_ready = 1; req_valid = 1; req_addr = 64'hBFFF_FFFF;
    cyc();
    check("r0_top_hit", rsp_hit, 1);
    check("r0_top_idx", rsp_idx, 0);
    check("r0_top_attr", rsp_attr, 3'h7);
    req_addr = 64'hC000_0000;
    cyc();
    check("r0_end_hit", rsp_hit, 0);
    check("r0_end_miss", miss_cnt, Stats ? 1 : 0);
    req_valid = 0;
    cyc();

    wr(3, 64'h1000_0000, 64'h1000, 3'b011);
    check("wr3_err", cfg_err, 0);
    wr(5, 64'h1000_0800, 64'h800, 3'b110);
    req_valid = 1; req_addr = 64'h1000_0900;
    cyc();
    check("prio_hit", rsp_hit, 1);
    check("prio_idx", rsp_idx, 3);
    check("prio_attr", rsp_attr, 3'b011);
    req_valid = 0;

    wr(2, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 3'b001);
    req_valid = 1; req_addr = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc();
    check("top_hit", rsp_hit, 1);
    check("top_idx", rsp_idx, 2);
    req_addr = 64'h0;
    cyc();
    check("wrap_hit", rsp_hit, 0);
    req_valid = 0;
    cyc();

    rand_phase(400);

    // Backpressure: one response held for three cycles, then back-to-back drain.
    req_valid = 1; req_addr = 64'h1000_0010;
    cyc();
    rsp_ready = 0; req_addr = 64'hBFFF_0000;
    #1;
    check("stall_ready", req_ready, 0);
    repeat (3) begin
      cyc();
      check("stall_valid", rsp_valid, 1);
      check("stall_idx", rsp_idx, 3);
      check("stall_attr", rsp_attr, 3'b011);
    end
    rsp_ready = 1;
    cyc();
    check("drain1_idx", rsp_idx, 0);
    req_addr = 64'hFFFF_FFFF_FFFF_FFF0;
    cyc();
    check("drain2_idx", rsp_idx, 2);
    req_valid = 0;
    cyc();
    check("drain_empty", rsp_valid, 0);

    wr(N, 64'h2000_0000, 64'h100, 3'b111);
    check("badidx_err", cfg_err, 1);
    cyc();
    check("badidx_err_clr", cfg_err, 0);

    cfg_lock = 1;
    wr(1, 64'h3000_0000, 64'h100, 3'b101);
    cfg_lock = 0;
    check("lock_set", locked, 1);
    check("lock_wr_err", cfg_err, 0);
    wr(1, 64'h5000_0000, 64'h100, 3'b010);
    check("locked_wr_err", cfg_err, 1);
    req_valid = 1; req_addr = 64'h3000_0010;
    cyc();
    check("locked_err_clr", cfg_err, 0);
    check("locked_keep_hit", rsp_hit, 1);
    check("locked_keep_idx", rsp_idx, 1);
    check("locked_keep_attr", rsp_attr, 3'b101);
    req_addr = 64'h5000_0010;
    cyc();
    check("locked_new_hit", rsp_hit, 0);
    req_valid = 0;
    cyc();

    rand_phase(200);

    req_valid = 1; rsp_ready = 1; req_addr = 64'h40;
    repeat (65540) cyc();
    check("miss_sat", miss_cnt, Stats ? 16'hFFFF : 16'h0);

    // Reset with a response pending and a request still offered.
    rsp_ready = 0;
    cyc();
    check("pre_rst_valid", rsp_valid, 1);
    rst_n = 0;
    cyc();
    check("rst_valid", rsp_valid, 0);
    check("rst_miss", miss_cnt, 0);
    check("rst_locked", locked, 0);
    check("rst_ready", req_ready, 1);
    rst_n = 1; req_valid = 0;
    cyc();
    check("post_rst_valid", rsp_valid, 0);
    rsp_ready = 1; req_valid = 1; req_addr = 64'h3000_0010;
    cyc();
    check("post_rst_r1_gone", rsp_hit, 0);
    req_addr = 64'h8000_0000;
    cyc();
    check("post_rst_r0_hit", rsp_hit, 1);
    req_valid = 0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
